bitbrick_seq_ctrl: RTL

//  Time-multiplexed sequencer for one 2-bit BitBrick plus shifter. Accepts one multiply per

---
 rtl/bitbrick_seq_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/bitbrick_seq_ctrl.sv
// Time-multiplexed 2-bit BitBrick sequencer: walks brick pairs, shift-accumulates into ACC_W.
// Optional zero-operand bypass: define BITBRICK_SEQ_ZERO_SKIP_EN.
module bitbrick_seq_ctrl #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [1:0]       a_prec,
  input  logic [1:0]       b_prec,
  input  logic             a_signed,
  input  logic             b_signed,
  output logic             brick_en,
  output logic [2:0]       brick_a,
  output logic [2:0]       brick_b,
  output logic [3:0]       brick_shift,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] na_m1;
    logic [1:0] nb_m1;
    logic       a_sgn;
    logic       b_sgn;
  } req_t;

  function automatic logic [1:0] last_idx(input logic [1:0] p);
    case (p)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  state_t             state, state_nx;
  req_t               req;
  logic [1:0]         i, j;
  logic [ACC_W-1:0]   acc;
  logic               zero_req, last_pair;
  logic [1:0]         ba_raw, bb_raw;
  logic [2:0]         ba_w, bb_w;
  logic [3:0]         shift_w;
  logic signed [5:0]  prod;
  logic [ACC_W-1:0]   pp;

`ifdef BITBRICK_SEQ_ZERO_SKIP_EN
  function automatic logic [7:0] mask_op(input logic [7:0] x, input logic [1:0] p);
    case (p)
      2'b00:   return {6'd0, x[1:0]};
      2'b01:   return {4'd0, x[3:0]};
      default: return x;
    endcase
  endfunction
  assign zero_req = (mask_op(a, a_prec) == 8'd0) || (mask_op(b, b_prec) == 8'd0);
`else
  assign zero_req = 1'b0;
`endif

  // Brick select: only the top brick of a signed operand carries its sign into bit 2.
  assign ba_raw    = req.a[{i, 1'b0} +: 2];
  assign bb_raw    = req.b[{j, 1'b0} +: 2];
  assign ba_w      = {req.a_sgn && (i == req.na_m1) && ba_raw[1], ba_raw};
  assign bb_w      = {req.b_sgn && (j == req.nb_m1) && bb_raw[1], bb_raw};
  assign shift_w   = {({1'b0, i} + {1'b0, j}), 1'b0};
  assign prod      = $signed({{3{ba_w[2]}}, ba_w}) * $signed({{3{bb_w[2]}}, bb_w});
  assign pp        = {{(ACC_W-6){prod[5]}}, prod} << shift_w;
  assign last_pair = (i == req.na_m1) && (j == req.nb_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = zero_req ? DONE : RUN;
      RUN:     if (last_pair) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state == IDLE);
    out_valid   = (state == DONE);
    brick_en    = (state == RUN);
    brick_a     = '0;
    brick_b     = '0;
    brick_shift = '0;
    if (state == RUN) begin
      brick_a     = ba_w;
      brick_b     = bb_w;
      brick_shift = shift_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req <= '0;
      i   <= '0;
      j   <= '0;
      acc <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          req <= '{a: a, b: b, na_m1: last_idx(a_prec), nb_m1: last_idx(b_prec),
                   a_sgn: a_signed, b_sgn: b_signed};
          i   <= '0;
          j   <= '0;
          acc <= '0;
        end
        RUN: begin
          acc <= acc + pp;
          if (i == req.na_m1) begin
            i <= '0;
            j <= j + 2'd1;
          end else begin
            i <= i + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign result = acc;
endmodule
